cnt60: RTL and testbench

CNT60 -- requirements
Module: cnt60

---
 rtl/cnt60_pkg.sv | 31 +++
 rtl/cnt60_seg7dec.sv | 19 +
 rtl/cnt60.sv | 55 +++++
 tb/tb_cnt60.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt60_pkg.sv
// cnt60_pkg: constants shared by the modulo-60 BCD counter and its
// 7-segment decoders.
//   DIGIT_W   : width of one BCD digit
//   LOW_MAX   : last value of the ones digit before it wraps
//   UP_MAX    : last value of the tens digit before it wraps
//   SEG_TABLE : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   SEG_BLANK : all segments off, shown for non-BCD codes 10-15
package cnt60_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;

   localparam logic [DIGIT_W-1:0] LOW_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] UP_MAX  = 4'd5;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [SEG_W-1:0] SEG_TABLE [0:9] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

endpackage

// File: rtl/cnt60_seg7dec.sv
// seg7dec: BCD digit to active-low 7-segment pattern, purely combinational.
//   digit : 4-bit input code
//   seg   : 7-bit active-low segments, bit order {g,f,e,d,c,b,a};
//           codes 10-15 are shown blank
module seg7dec
   import cnt60_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (digit <= LOW_MAX) begin
         seg = SEG_TABLE[digit];
      end
   end

endmodule

// File: rtl/cnt60.sv
// cnt60: modulo-60 two-digit BCD counter with 7-segment outputs.
//   CLK      : system clock, rising edge
//   RST      : synchronous active-high reset, overrides cnten
//   cnten    : count enable, one step per rising edge while high
//   digitlow : ones digit register (0-9)
//   digitup  : tens digit register (0-5)
//   cnt60up  : combinational carry, high while enabled at count 59
//   hex0     : active-low segments of digitlow
//   hex1     : active-low segments of digitup
module cnt60
   import cnt60_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               cnten,
   output logic [DIGIT_W-1:0] digitlow,
   output logic [DIGIT_W-1:0] digitup,
   output logic               cnt60up,
   output logic [SEG_W-1:0]   hex0,
   output logic [SEG_W-1:0]   hex1
);

   // Comparisons use >= so that out-of-range digits (e.g. after a force)
   // recover to zero on the next enabled edge instead of counting upward.
   always_ff @(posedge CLK) begin
      if (RST) begin
         digitlow <= '0;
         digitup  <= '0;
      end else if (cnten) begin
         if (digitlow >= LOW_MAX) begin
            digitlow <= '0;
            if (digitup >= UP_MAX) begin
               digitup <= '0;
            end else begin
               digitup <= digitup + 1'b1;
            end
         end else begin
            digitlow <= digitlow + 1'b1;
         end
      end
   end

   assign cnt60up = cnten & (digitup == UP_MAX) & (digitlow == LOW_MAX);

   seg7dec u_dec_low (
      .digit (digitlow),
      .seg   (hex0)
   );

   seg7dec u_dec_up (
      .digit (digitup),
      .seg   (hex1)
   );

endmodule

// File: tb/tb_cnt60.sv
module tb_cnt60;

   logic       CLK;
   logic       RST;
   logic       cnten;
   logic [3:0] digitlow;
   logic [3:0] digitup;
   logic       cnt60up;
   logic [6:0] hex0;
   logic [6:0] hex1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // reference state: plain integer digits
   int m_low;
   int m_up;

   logic [6:0] seg_ref [0:15];

   cnt60 dut (
      .CLK      (CLK),
      .RST      (RST),
      .cnten    (cnten),
      .digitlow (digitlow),
      .digitup  (digitup),
      .cnt60up  (cnt60up),
      .hex0     (hex0),
      .hex1     (hex1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference step from the counting rules: legal counts advance as an
   // integer modulo 60; illegal digits follow the recovery rules.
   task automatic model_edge(input logic rst, input logic en);
      int n;
      if (rst) begin
         m_low = 0;
         m_up  = 0;
      end else if (en) begin
         if (m_low <= 9 && m_up <= 5) begin
            n     = (m_up * 10 + m_low + 1) % 60;
            m_up  = n / 10;
            m_low = n % 10;
         end else if (m_low < 9) begin
            m_low = m_low + 1;
         end else begin
            m_low = 0;
            m_up  = (m_up < 5) ? m_up + 1 : 0;
         end
      end
   endtask

   task automatic check(input string tag);
      logic [3:0] e_low;
      logic [3:0] e_up;
      logic       e_cy;
      e_low = 4'(m_low);
      e_up  = 4'(m_up);
      e_cy  = cnten && (m_low == 9) && (m_up == 5);
      checks++;
      assert (digitlow === e_low) else begin
         errors++;
         $error("FAIL %s digitlow observed=%0d expected=%0d", tag, digitlow, e_low);
      end
      checks++;
      assert (digitup === e_up) else begin
         errors++;
         $error("FAIL %s digitup observed=%0d expected=%0d", tag, digitup, e_up);
      end
      checks++;
      assert (cnt60up === e_cy) else begin
         errors++;
         $error("FAIL %s cnt60up observed=%b expected=%b", tag, cnt60up, e_cy);
      end
      checks++;
      assert (hex0 === seg_ref[e_low]) else begin
         errors++;
         $error("FAIL %s hex0 observed=%b expected=%b", tag, hex0, seg_ref[e_low]);
      end
      checks++;
      assert (hex1 === seg_ref[e_up]) else begin
         errors++;
         $error("FAIL %s hex1 observed=%b expected=%b", tag, hex1, seg_ref[e_up]);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge(RST, cnten);
      #1;
   endtask

   task automatic force_digits(input int up, input int low);
      force dut.digitlow = 4'(low);
      force dut.digitup  = 4'(up);
      #1;
      release dut.digitlow;
      release dut.digitup;
      #1;
      m_low = low;
      m_up  = up;
   endtask

   initial begin
      seg_ref[0]  = 7'b1000000;
      seg_ref[1]  = 7'b1111001;
      seg_ref[2]  = 7'b0100100;
      seg_ref[3]  = 7'b0110000;
      seg_ref[4]  = 7'b0011001;
      seg_ref[5]  = 7'b0010010;
      seg_ref[6]  = 7'b0000010;
      seg_ref[7]  = 7'b1111000;
      seg_ref[8]  = 7'b0000000;
      seg_ref[9]  = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_ref[i] = 7'b1111111;
      m_low = 0;
      m_up  = 0;

      // reset with enable high
      RST   = 1'b1;
      cnten = 1'b1;
      #2;
      tick();
      RST = 1'b0;
      check("reset");

      // first ten enabled edges: 01..09, 10
      for (int i = 0; i < 10; i++) begin
         tick();
         check("count10");
      end

      // from reset, 59 edges reach 59 with carry, then wrap
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 59; i++) tick();
      check("at59");
      tick();
      check("wrap00");

      // hold at 37 with enable low
      for (int i = 0; i < 37; i++) tick();
      check("at37");
      cnten = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold37");
      end
      cnten = 1'b1;

      // force ones to 9 repeatedly, stepping tens through 1..5 then wrap
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int k = 0; k < 6; k++) begin
         force_digits(m_up, 9);
         check("forced9");
         tick();
         check("tensstep");
      end

      // illegal ones digit 12: blank, then recover with tens increment
      force_digits(2, 12);
      check("low12");
      tick();
      check("low12rec");

      // illegal tens 7 with ones 3: ones keeps counting, tens blank
      force_digits(7, 3);
      check("up7");
      tick();
      check("up7step");

      // illegal tens 7 with ones 9: both wrap to zero
      force_digits(7, 9);
      tick();
      check("up7wrap");

      // enable low while at 59: no carry
      force_digits(5, 9);
      cnten = 1'b0;
      #1;
      check("hold59");
      cnten = 1'b1;
      #1;
      check("carry59");

      // randomized enable and occasional reset
      for (int i = 0; i < 400; i++) begin
         cnten = 1'($urandom_range(0, 3) != 0);
         RST   = 1'($urandom_range(0, 40) == 0);
         #1;
         check("rand_pre");
         tick();
         RST = 1'b0;
         check("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
